// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/retire sequencer owning the architectural PC.
// Optional build macro PC_MISALIGN_TRAP_EN enables the sticky misalignment trap.
module fetch_sequencer #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_1000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt_req,
   output logic [XLEN-1:0] pc,
   output logic            halted,
   output logic [31:0]     instret,
   output logic            misalign_trap
);

   typedef enum logic [2:0] {StBoot, StReq, StWait, StIssue, StHalt} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instr_pc_q, instr_pc_d;
   logic [31:0]     instret_q, instret_d;
   logic [XLEN-1:0] next_pc;
`ifdef PC_MISALIGN_TRAP_EN
   logic            trap_q, trap_d;
`endif

   assign next_pc = redirect_valid ? redirect_pc : instr_pc_q + XLEN'(4);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      instret_d  = instret_q;
`ifdef PC_MISALIGN_TRAP_EN
      trap_d     = trap_q;
`endif
      case (state_q)
         StBoot: state_d = StReq;
         StReq: begin
            // halt wins over a ready imem so no request is ever left dangling
            if (halt_req) begin
               state_d = StHalt;
            end else if (imem_req_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (imem_rsp_valid) begin
               instr_d    = imem_rsp_data;
               instr_pc_d = pc_q;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            if (instr_ready) begin
               instret_d = instret_q + 32'd1;
`ifdef PC_MISALIGN_TRAP_EN
               if (next_pc[1:0] != 2'b00) begin
                  trap_d  = 1'b1;
                  state_d = StHalt;
               end else begin
                  pc_d    = next_pc;
                  state_d = halt_req ? StHalt : StReq;
               end
`else
               pc_d    = next_pc & ~XLEN'(3);
               state_d = halt_req ? StHalt : StReq;
`endif
            end
         end
         StHalt:  state_d = StHalt;
         default: state_d = StHalt;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StBoot;
         pc_q       <= RESET_VECTOR;
         instr_q    <= '0;
         instr_pc_q <= '0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         instret_q  <= instret_d;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trap_q <= 1'b0;
      end else begin
         trap_q <= trap_d;
      end
   end
   assign misalign_trap = trap_q;
`else
   assign misalign_trap = 1'b0;
`endif

   assign imem_req_valid = (state_q == StReq) && !halt_req;
   assign imem_addr      = pc_q;
   assign instr_valid    = (state_q == StIssue);
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign pc             = pc_q;
   assign halted         = (state_q == StHalt);
   assign instret        = instret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: the bench plays imem and execute,
// pushing each returned word with its expected PC and popping it at issue.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt_req = 1'b0;
   logic [31:0] pc;
   logic        halted;
   logic [31:0] instret;
   logic        misalign_trap;

   fetch_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .pc             (pc),
      .halted         (halted),
      .instret        (instret),
      .misalign_trap  (misalign_trap)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] sb_q[$];
   logic [31:0] exp_pc;
   logic [31:0] exp_instret;
   logic [31:0] exp_instr;
   logic        exp_trap;
   logic        exp_halt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset at once, check values before any clock edge, release, leave DUT in REQ.
   task automatic do_reset();
      rst = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_trap", {31'd0, misalign_trap}, 32'd0);
      check("rst_pc", pc, 32'h0000_1000);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_instret", instret, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      exp_pc      = 32'h0000_1000;
      exp_instret = '0;
      exp_instr   = '0;
      exp_trap    = 1'b0;
      exp_halt    = 1'b0;
      sb_q.delete();
      check("boot_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20; i++) begin
         if (imem_req_valid) break;
         tick();
      end
      check("req_seen", {31'd0, imem_req_valid}, 32'd1);
   endtask

   task automatic fetch_one(input logic [31:0] word, input logic redir, input logic [31:0] rpc,
                            input int req_wait, input int rsp_wait, input int stall,
                            input logic hlt);
      logic [63:0] item;
      logic [31:0] nxt;
      wait_req();
      check("req_addr", imem_addr, exp_pc);
      for (int i = 0; i < req_wait; i++) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hBAD0_BAD0;
         tick();
         check("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
         check("req_hold_addr", imem_addr, exp_pc);
         check("stray_rsp_instr", instr, exp_instr);
      end
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < rsp_wait; i++) begin
         tick();
         check("wait_no_issue", {31'd0, instr_valid}, 32'd0);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word;
      sb_q.push_back({exp_pc, word});
      tick();
      imem_rsp_valid = 1'b0;
      check("issue_valid", {31'd0, instr_valid}, 32'd1);
      if (sb_q.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
      end else begin
         item      = sb_q.pop_front();
         exp_instr = item[31:0];
         check("issue_instr", instr, item[31:0]);
         check("issue_pc", instr_pc, item[63:32]);
      end
      for (int i = 0; i < stall; i++) begin
         redirect_valid = 1'b1;
         redirect_pc    = 32'h0000_3000;
         tick();
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_pc", pc, exp_pc);
      end
      instr_ready    = 1'b1;
      redirect_valid = redir;
      redirect_pc    = rpc;
      halt_req       = hlt;
      tick();
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      halt_req       = 1'b0;
      nxt         = redir ? rpc : exp_pc + 32'd4;
      exp_instret = exp_instret + 32'd1;
      exp_halt    = hlt;
`ifdef PC_MISALIGN_TRAP_EN
      if (nxt[1:0] != 2'b00) begin
         exp_trap = 1'b1;
         exp_halt = 1'b1;
      end else begin
         exp_pc = nxt;
      end
`else
      exp_pc = {nxt[31:2], 2'b00};
`endif
      check("retire_instret", instret, exp_instret);
      check("retire_pc", pc, exp_pc);
      check("retire_trap", {31'd0, misalign_trap}, {31'd0, exp_trap});
      check("retire_halted", {31'd0, halted}, {31'd0, exp_halt});
      if (exp_halt) begin
         check("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
      end else begin
         check("next_req_valid", {31'd0, imem_req_valid}, 32'd1);
         check("next_req_addr", imem_addr, exp_pc);
      end
   endtask

   initial begin
      do_reset();
      // Zero-wait fetch, fall-through
      fetch_one(32'h0000_0013, 1'b0, 32'd0, 0, 0, 0, 1'b0);
      // Redirect, with a redirect offered while execute is still busy
      fetch_one(32'h1111_1111, 1'b1, 32'h0000_2010, 0, 0, 2, 1'b0);
      // Request back-pressure with stray responses, slow response
      fetch_one(32'h2222_2222, 1'b0, 32'd0, 5, 3, 0, 1'b0);
      // Wrap of the fall-through address
      fetch_one(32'h3333_3333, 1'b1, 32'hFFFF_FFFC, 0, 0, 0, 1'b0);
      fetch_one(32'h4444_4444, 1'b0, 32'd0, 1, 1, 0, 1'b0);
      check("wrap_addr", exp_pc, 32'h0000_0000);
      // Misaligned redirect target
      fetch_one(32'h5555_5555, 1'b1, 32'h0000_2012, 0, 0, 0, 1'b0);
      if (!exp_halt) begin
         fetch_one(32'h6666_6666, 1'b0, 32'd0, 0, 0, 0, 1'b0);
      end

      // Reset while a fetch is outstanding; late response afterwards is ignored
      do_reset();
      fetch_one(32'h7777_7777, 1'b0, 32'd0, 0, 0, 0, 1'b0);
      wait_req();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      check("mid_wait_state", {31'd0, instr_valid}, 32'd0);
      do_reset();
      fetch_one(32'h8888_8888, 1'b0, 32'd0, 2, 0, 0, 1'b0);

      // Halt at retire
      fetch_one(32'h9999_9999, 1'b0, 32'd0, 0, 0, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("halt_stays", {31'd0, halted}, 32'd1);
         check("halt_quiet", {31'd0, imem_req_valid}, 32'd0);
      end

      // Halt in REQ beats a ready imem
      do_reset();
      wait_req();
      halt_req       = 1'b1;
      imem_req_ready = 1'b1;
      tick();
      halt_req       = 1'b0;
      imem_req_ready = 1'b0;
      check("req_halt_halted", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         imem_rsp_valid = 1'b1;
         tick();
         imem_rsp_valid = 1'b0;
         check("req_halt_quiet", {31'd0, imem_req_valid}, 32'd0);
         check("req_halt_no_issue", {31'd0, instr_valid}, 32'd0);
      end
      check("req_halt_instret", instret, 32'd0);
      check("req_halt_pc", pc, 32'h0000_1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
